// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; grant at N -> rsp_valid at N+2.
// Backpressure: rsp_* held until rsp_ready; no new grant while a response is pending.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [2*WIDTH-1:0]    req_op1,
  input  logic [2*WIDTH-1:0]    req_op2,
  input  logic [2*OP_WIDTH-1:0] req_alu_op,
  output logic [1:0]            req_ready,
  output logic [WIDTH-1:0]      alu_op1,
  output logic [WIDTH-1:0]      alu_op2,
  output logic [OP_WIDTH-1:0]   alu_op_out,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [WIDTH-1:0]    op1;
    logic [WIDTH-1:0]    op2;
  } req_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_vld;
  logic   grant_id;
  req_t   grant_dat;

  always_comb begin
    grant_vld = rst_n && (state == IDLE) && (req_valid != 2'b00);
    // Tie goes to whoever did not win last; reset value 1 favours requester 0.
    if (req_valid == 2'b11) grant_id = ~last_grant;
    else                    grant_id = req_valid[1];
    if (grant_id) grant_dat = '{op: req_alu_op[2*OP_WIDTH-1:OP_WIDTH],
                                op1: req_op1[2*WIDTH-1:WIDTH],
                                op2: req_op2[2*WIDTH-1:WIDTH]};
    else          grant_dat = '{op: req_alu_op[OP_WIDTH-1:0],
                                op1: req_op1[WIDTH-1:0],
                                op2: req_op2[WIDTH-1:0]};
    req_ready = 2'b00;
    if (grant_vld) req_ready = grant_id ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_op_out <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        alu_op1    <= grant_dat.op1;
        alu_op2    <= grant_dat.op2;
        alu_op_out <= grant_dat.op;
        rsp_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int OW = 4;
  localparam logic [OW-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [2*W-1:0]  req_op1, req_op2;
  logic [2*OW-1:0] req_alu_op;
  logic [1:0]      req_ready;
  logic [W-1:0]    alu_op1, alu_op2;
  logic [OW-1:0]   alu_op_out;
  logic [W-1:0]    alu_result;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready;
  logic [W-1:0]    rsp_result;
  logic            rsp_zero, rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op1(req_op1),
    .req_op2(req_op2), .req_alu_op(req_alu_op), .req_ready(req_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_out(alu_op_out),
    .alu_result(alu_result), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id)
  );

  always_comb begin
    case (alu_op_out)
      OP_ADD:  alu_result = alu_op1 + alu_op2;
      OP_SUB:  alu_result = alu_op1 - alu_op2;
      OP_AND:  alu_result = alu_op1 & alu_op2;
      OP_OR:   alu_result = alu_op1 | alu_op2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OW-1:0] op);
    req_op1[id*W +: W]     = a;
    req_op2[id*W +: W]     = b;
    req_alu_op[id*OW +: OW] = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [OW-1:0] op;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int gcyc[$];
    int gid[$];
    int rcyc[$];
    int rid[$];
    logic got;

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op1 = '0; req_op2 = '0; req_alu_op = '0;

    vecs[0] = '{0, 32'd5,    32'd7,    OP_ADD, 32'd12,        1'b0};
    vecs[1] = '{1, 32'd3,    32'd3,    OP_SUB, 32'd0,         1'b1};
    vecs[2] = '{1, 32'd0,    32'd1,    OP_SUB, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{0, 32'hF0,   32'h3C,   OP_AND, 32'h30,        1'b0};
    vecs[4] = '{1, 32'hF0,   32'h0F,   OP_OR,  32'hFF,        1'b0};

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_op1", alu_op1, 0);
    rst_n = 1'b1;

    // Single-requester vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      set_lane(vecs[i].id, vecs[i].op1, vecs[i].op2, vecs[i].op);
      req_valid = (vecs[i].id == 1) ? 2'b10 : 2'b01;
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (req_ready != 2'b00) begin got = 1'b1; break; end
        @(negedge clk);
      end
      chk($sformatf("v%0d_grant_seen", i), got, 1);
      chk($sformatf("v%0d_req_ready", i), req_ready, (vecs[i].id == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk($sformatf("v%0d_exec_rsp_valid", i), rsp_valid, 0);
      chk($sformatf("v%0d_exec_req_ready", i), req_ready, 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].exp_res);
      chk($sformatf("v%0d_rsp_zero", i), rsp_zero, vecs[i].exp_zero);
      chk($sformatf("v%0d_rsp_id", i), rsp_id, vecs[i].id);
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rsp_drop", i), rsp_valid, 0);
      rsp_ready = 1'b0;
    end

    // Fairness: both valid continuously, consumer always ready
    do_reset();
    set_lane(0, 32'd10, 32'd20, OP_ADD);
    set_lane(1, 32'd50, 32'd8,  OP_SUB);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 2'b00) begin gcyc.push_back(c); gid.push_back(int'(req_ready[1])); end
      if (rsp_valid) begin
        rcyc.push_back(c); rid.push_back(int'(rsp_id));
        chk($sformatf("fair_result_c%0d", c), rsp_result, rsp_id ? 32'd42 : 32'd30);
      end
      if (c >= 10) req_valid = 2'b00;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("fair_grant_count", gid.size(), 4);
    chk("fair_rsp_count", rid.size(), 4);
    for (int i = 0; i < 4 && i < gid.size() && i < rid.size(); i++) begin
      chk($sformatf("fair_gid%0d", i), gid[i], i % 2);
      chk($sformatf("fair_gcyc%0d", i), gcyc[i], 3 * i);
      chk($sformatf("fair_rid%0d", i), rid[i], i % 2);
      chk($sformatf("fair_rcyc%0d", i), rcyc[i], 3 * i + 2);
    end

    // Response backpressure: last grant was 1, so requester 0 wins next
    req_valid = 2'b11;
    #1;
    chk("bp_grant0", req_ready, 2'b01);
    @(negedge clk);
    #1;
    chk("bp_exec_req_ready", req_ready, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_valid_k%0d", k), rsp_valid, 1);
      chk($sformatf("bp_result_k%0d", k), rsp_result, 32'd30);
      chk($sformatf("bp_id_k%0d", k), rsp_id, 0);
      chk($sformatf("bp_req_ready_k%0d", k), req_ready, 0);
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_after_rsp_valid", rsp_valid, 0);
    chk("bp_after_grant1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("bp_second_result", rsp_result, 32'd42);
    chk("bp_second_id", rsp_id, 1);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Operand change after acceptance has no effect
    set_lane(0, 32'd100, 32'd1, OP_ADD);
    req_valid = 2'b01;
    #1;
    chk("chg_grant", req_ready, 2'b01);
    @(negedge clk);
    req_op1[W-1:0] = 32'd999;
    req_valid = 2'b00;
    #1;
    chk("chg_alu_op1", alu_op1, 32'd100);
    @(negedge clk);
    #1;
    chk("chg_result", rsp_result, 32'd101);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during EXEC drops the operation
    set_lane(1, 32'd9, 32'd4, OP_SUB);
    req_valid = 2'b10;
    #1;
    chk("rexec_grant", req_ready, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rexec_inreset_req_ready", req_ready, 0);
    @(negedge clk);
    #1;
    chk("rexec_rsp_valid", rsp_valid, 0);
    chk("rexec_rsp_result", rsp_result, 0);
    chk("rexec_rsp_zero", rsp_zero, 0);
    chk("rexec_rsp_id", rsp_id, 0);
    chk("rexec_alu_op1", alu_op1, 0);
    chk("rexec_alu_op2", alu_op2, 0);
    chk("rexec_alu_op_out", alu_op_out, 0);
    chk("rexec_req_ready", req_ready, 0);
    set_lane(0, 32'd999, 32'd1, OP_ADD);
    rst_n = 1'b1;
    #1;
    chk("rexec_first_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rexec_no_stale_rsp", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("rexec_post_valid", rsp_valid, 1);
    chk("rexec_post_result", rsp_result, 32'd1000);
    chk("rexec_post_id", rsp_id, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
